// File: rtl/regfile_writeback.sv
// Write-side front end for the integer register file: merges ALU results and in-order load returns onto one write port.
// Optional macro REGWB_BYPASS_EN: busy clears one cycle earlier and O_fwdN_hit flags O_data as a bypass for rsN.
module regfile_writeback #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 4,
    parameter int LQ_DEPTH = 2
) (
    input  logic            I_clk,
    input  logic            I_rstn,
    input  logic            I_alu_valid,
    input  logic [RA_W-1:0] I_alu_rd,
    input  logic [XLEN-1:0] I_alu_data,
    input  logic            I_ld_issue,
    input  logic [RA_W-1:0] I_ld_rd,
    output logic            O_ld_issue_ready,
    input  logic            I_ld_valid,
    input  logic [XLEN-1:0] I_ld_data,
    output logic            O_ld_ready,
    input  logic [RA_W-1:0] I_rs1,
    input  logic [RA_W-1:0] I_rs2,
    output logic            O_rs1_busy,
    output logic            O_rs2_busy,
    output logic            O_fwd1_hit,
    output logic            O_fwd2_hit,
    output logic            O_regwen,
    output logic [RA_W-1:0] O_rd,
    output logic [XLEN-1:0] O_data
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << RA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

    logic [RA_W-1:0]  fifo_mem [LQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             skid_valid;
    logic [RA_W-1:0]  skid_rd;
    logic [XLEN-1:0]  skid_data;
    logic             out_regwen;
    logic [RA_W-1:0]  out_rd;
    logic [XLEN-1:0]  out_data;
    logic [NREG-1:0]  busy, busy_next;

    logic            ld_push, ld_pop;
    logic            win_valid, win_is_ld, win_write;
    logic [RA_W-1:0] win_rd;
    logic [XLEN-1:0] win_data;
    logic            skid_load, skid_clear;

    // Handshakes: issue is taken on I_ld_issue & O_ld_issue_ready, a return on I_ld_valid & O_ld_ready;
    // both readies come from registered state only and are forced low while reset is asserted.
    assign O_ld_issue_ready = I_rstn & (fifo_count < DEPTH_C);
    assign O_ld_ready       = I_rstn & ~skid_valid & (fifo_count != '0);
    assign ld_push          = I_ld_issue & O_ld_issue_ready;
    assign ld_pop           = I_ld_valid & O_ld_ready;

    // Write-stage arbitration: ALU, then skid, then the load arriving now.
    always_comb begin
        win_valid  = 1'b0;
        win_is_ld  = 1'b0;
        win_rd     = '0;
        win_data   = '0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (I_alu_valid) begin
            win_valid = 1'b1;
            win_rd    = I_alu_rd;
            win_data  = I_alu_data;
            skid_load = ld_pop;
        end else if (skid_valid) begin
            win_valid  = 1'b1;
            win_is_ld  = 1'b1;
            win_rd     = skid_rd;
            win_data   = skid_data;
            skid_clear = 1'b1;
        end else if (ld_pop) begin
            win_valid = 1'b1;
            win_is_ld = 1'b1;
            win_rd    = fifo_mem[rd_ptr];
            win_data  = I_ld_data;
        end
    end

    // x0 writes are consumed here without ever reaching the file.
    assign win_write = win_valid & (win_rd != '0);

    always_ff @(posedge I_clk) begin
        if (ld_push) fifo_mem[wr_ptr] <= I_ld_rd;
    end

    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (ld_push) wr_ptr <= wr_ptr + 1'b1;
            if (ld_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({ld_push, ld_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            skid_valid <= 1'b0;
            skid_rd    <= '0;
            skid_data  <= '0;
        end else if (skid_load) begin
            skid_valid <= 1'b1;
            skid_rd    <= fifo_mem[rd_ptr];
            skid_data  <= I_ld_data;
        end else if (skid_clear) begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            out_regwen <= 1'b0;
            out_rd     <= '0;
            out_data   <= '0;
        end else begin
            out_regwen <= win_write;
            if (win_write) begin
                out_rd   <= win_rd;
                out_data <= win_data;
            end
        end
    end

`ifdef REGWB_BYPASS_EN
    always_comb begin
        busy_next = busy;
        if (win_write && win_is_ld) busy_next[win_rd] = 1'b0;
        if (ld_push && (I_ld_rd != '0)) busy_next[I_ld_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign O_fwd1_hit = out_regwen & (out_rd != '0) & (out_rd == I_rs1);
    assign O_fwd2_hit = out_regwen & (out_rd != '0) & (out_rd == I_rs2);
`else
    // Remembers whether the write now on the port came from a load, so busy drops once the file holds it.
    logic out_is_ld;

    always_ff @(posedge I_clk) begin
        if (!I_rstn) out_is_ld <= 1'b0;
        else         out_is_ld <= win_write & win_is_ld;
    end

    always_comb begin
        busy_next = busy;
        if (out_regwen && out_is_ld) busy_next[out_rd] = 1'b0;
        if (ld_push && (I_ld_rd != '0)) busy_next[I_ld_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign O_fwd1_hit = 1'b0;
    assign O_fwd2_hit = 1'b0;
`endif

    always_ff @(posedge I_clk) begin
        if (!I_rstn) busy <= '0;
        else         busy <= busy_next;
    end

    assign O_rs1_busy = (I_rs1 != '0) & busy[I_rs1];
    assign O_rs2_busy = (I_rs2 != '0) & busy[I_rs2];
    assign O_regwen   = out_regwen;
    assign O_rd       = out_rd;
    assign O_data     = out_data;
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios then randomized traffic against a queue-based model.
module tb_regfile_writeback;
    localparam int XLEN     = 32;
    localparam int RA_W     = 4;
    localparam int LQ_DEPTH = 2;
    localparam int EW       = RA_W + XLEN;

    logic            clk;
    logic            I_rstn;
    logic            I_alu_valid;
    logic [RA_W-1:0] I_alu_rd;
    logic [XLEN-1:0] I_alu_data;
    logic            I_ld_issue;
    logic [RA_W-1:0] I_ld_rd;
    logic            O_ld_issue_ready;
    logic            I_ld_valid;
    logic [XLEN-1:0] I_ld_data;
    logic            O_ld_ready;
    logic [RA_W-1:0] I_rs1, I_rs2;
    logic            O_rs1_busy, O_rs2_busy;
    logic            O_fwd1_hit, O_fwd2_hit;
    logic            O_regwen;
    logic [RA_W-1:0] O_rd;
    logic [XLEN-1:0] O_data;

    regfile_writeback #(.XLEN(XLEN), .RA_W(RA_W), .LQ_DEPTH(LQ_DEPTH)) dut (
        .I_clk(clk), .I_rstn(I_rstn),
        .I_alu_valid(I_alu_valid), .I_alu_rd(I_alu_rd), .I_alu_data(I_alu_data),
        .I_ld_issue(I_ld_issue), .I_ld_rd(I_ld_rd), .O_ld_issue_ready(O_ld_issue_ready),
        .I_ld_valid(I_ld_valid), .I_ld_data(I_ld_data), .O_ld_ready(O_ld_ready),
        .I_rs1(I_rs1), .I_rs2(I_rs2), .O_rs1_busy(O_rs1_busy), .O_rs2_busy(O_rs2_busy),
        .O_fwd1_hit(O_fwd1_hit), .O_fwd2_hit(O_fwd2_hit),
        .O_regwen(O_regwen), .O_rd(O_rd), .O_data(O_data)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding load rds, returned-but-unwritten loads, and expected writes.
    int            lq[$];
    logic [EW-1:0] wait_q[$];
    logic [EW-1:0] exp_q[$];
    bit            m_busy[16];
    bit            m_regwen;
    int            m_rd;
    int            clr_pend;
    int            n_cmp, n_err;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        lq.delete();
        wait_q.delete();
        exp_q.delete();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_regwen = 1'b0;
        m_rd     = 0;
        clr_pend = -1;
    endtask

    task automatic check_outputs(input bit rstn, input int rs1, input int rs2);
        logic [EW-1:0] e;
        bit            f1, f2;
        check_eq("regwen", O_regwen, m_regwen);
        if (m_regwen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rd_data", {O_rd, O_data}, e);
        end
        check_eq("issue_ready", O_ld_issue_ready, rstn && (lq.size() < LQ_DEPTH));
        check_eq("ld_ready", O_ld_ready, rstn && (wait_q.size() == 0) && (lq.size() > 0));
        check_eq("rs1_busy", O_rs1_busy, (rs1 != 0) && m_busy[rs1]);
        check_eq("rs2_busy", O_rs2_busy, (rs2 != 0) && m_busy[rs2]);
`ifdef REGWB_BYPASS_EN
        f1 = m_regwen && (m_rd != 0) && (m_rd == rs1);
        f2 = m_regwen && (m_rd != 0) && (m_rd == rs2);
`else
        f1 = 1'b0;
        f2 = 1'b0;
`endif
        check_eq("fwd1_hit", O_fwd1_hit, f1);
        check_eq("fwd2_hit", O_fwd2_hit, f2);
    endtask

    task automatic model_step(input bit rstn, input bit alu_v, input int alu_rd, input logic [XLEN-1:0] alu_d,
                              input bit iss, input int iss_rd, input bit lv, input logic [XLEN-1:0] ld_d);
        bit            iss_rdy, ld_rdy, win_ok, is_ld;
        int            w_rd, r;
        logic [XLEN-1:0] w_d;
        logic [EW-1:0] e;
        if (!rstn) begin
            model_reset();
            return;
        end
        iss_rdy = lq.size() < LQ_DEPTH;
        ld_rdy  = (wait_q.size() == 0) && (lq.size() > 0);
        if (clr_pend >= 0) m_busy[clr_pend] = 1'b0;
        clr_pend = -1;
        if (lv && ld_rdy) begin
            r = lq.pop_front();
            wait_q.push_back({RA_W'(r), ld_d});
        end
        if (iss && iss_rdy) lq.push_back(iss_rd);
        win_ok = 1'b0;
        is_ld  = 1'b0;
        w_rd   = 0;
        w_d    = '0;
        if (alu_v) begin
            win_ok = 1'b1;
            w_rd   = alu_rd;
            w_d    = alu_d;
        end else if (wait_q.size() > 0) begin
            e      = wait_q.pop_front();
            win_ok = 1'b1;
            is_ld  = 1'b1;
            w_rd   = int'(e[XLEN +: RA_W]);
            w_d    = e[XLEN-1:0];
        end
        m_regwen = win_ok && (w_rd != 0);
        if (m_regwen) begin
            m_rd = w_rd;
            exp_q.push_back({RA_W'(w_rd), w_d});
            if (is_ld) begin
`ifdef REGWB_BYPASS_EN
                m_busy[w_rd] = 1'b0;
`else
                clr_pend = w_rd;
`endif
            end
        end
        if (iss && iss_rdy && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    endtask

    // Driver: apply one cycle of inputs at the falling edge, check, advance the model, wait for the next falling edge.
    task automatic run_cycle(input bit rstn, input bit alu_v, input int alu_rd, input logic [XLEN-1:0] alu_d,
                             input bit iss, input int iss_rd, input bit lv, input logic [XLEN-1:0] ld_d,
                             input int rs1, input int rs2);
        I_rstn      = rstn;
        I_alu_valid = alu_v;
        I_alu_rd    = alu_rd[RA_W-1:0];
        I_alu_data  = alu_d;
        I_ld_issue  = iss;
        I_ld_rd     = iss_rd[RA_W-1:0];
        I_ld_valid  = lv;
        I_ld_data   = ld_d;
        I_rs1       = rs1[RA_W-1:0];
        I_rs2       = rs2[RA_W-1:0];
        #1;
        check_outputs(rstn, rs1, rs2);
        model_step(rstn, alu_v, alu_rd, alu_d, iss, iss_rd, lv, ld_d);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input int rs1, input int rs2);
        for (int i = 0; i < n; i++) run_cycle(1, 0, 0, '0, 0, 0, 0, '0, rs1, rs2);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        I_rstn = 1'b0; I_alu_valid = 1'b1; I_alu_rd = 4'd5; I_alu_data = '1;
        I_ld_issue = 1'b0; I_ld_rd = '0; I_ld_valid = 1'b0; I_ld_data = '0;
        I_rs1 = '0; I_rs2 = '0;
        model_reset();
        @(negedge clk);

        // Reset held with ALU traffic present
        for (int i = 0; i < 3; i++) run_cycle(0, 1, 5, 32'hFFFF_FFFF, 1, 3, 1, 32'h1, 5, 3);
        check_eq("reset_rd_data", {O_rd, O_data}, '0);
        idle(1, 0, 0);

        // ALU path, then an ALU write to x0
        run_cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, '0, 5, 0);
        check_eq("alu_rd5", {O_regwen, O_rd, O_data}, {1'b1, 4'd5, 32'hDEADBEEF});
        idle(1, 5, 0);
        run_cycle(1, 1, 0, 32'h0BAD_0BAD, 0, 0, 0, '0, 0, 0);
        check_eq("alu_x0", O_regwen, 1'b0);
        idle(1, 0, 0);

        // Load to x3 and its scoreboard lifetime
        run_cycle(1, 0, 0, '0, 1, 3, 0, '0, 3, 0);
        idle(2, 3, 0);
        run_cycle(1, 0, 0, '0, 0, 0, 1, 32'h12345678, 3, 0);
        check_eq("ld_rd3", {O_regwen, O_rd, O_data}, {1'b1, 4'd3, 32'h12345678});
        idle(3, 3, 3);

        // Load return and ALU write in the same cycle
        run_cycle(1, 0, 0, '0, 1, 7, 0, '0, 7, 2);
        run_cycle(1, 1, 2, 32'hB, 0, 0, 1, 32'hA, 7, 2);
        check_eq("conflict_alu", {O_regwen, O_rd, O_data}, {1'b1, 4'd2, 32'hB});
        check_eq("conflict_ldrdy", O_ld_ready, 1'b0);
        run_cycle(1, 0, 0, '0, 1, 9, 1, 32'h5, 7, 9);
        check_eq("conflict_ld", {O_regwen, O_rd, O_data}, {1'b1, 4'd7, 32'hA});
        idle(3, 7, 9);
        run_cycle(1, 0, 0, '0, 0, 0, 1, 32'h99, 9, 0);
        idle(3, 9, 0);

        // Issue FIFO full: third issue ignored
        run_cycle(1, 0, 0, '0, 1, 1, 0, '0, 1, 2);
        run_cycle(1, 0, 0, '0, 1, 2, 0, '0, 1, 2);
        check_eq("fifo_full", O_ld_issue_ready, 1'b0);
        run_cycle(1, 0, 0, '0, 1, 4, 0, '0, 4, 1);
        run_cycle(1, 0, 0, '0, 0, 0, 1, 32'h11, 4, 2);
        run_cycle(1, 0, 0, '0, 0, 0, 1, 32'h22, 4, 1);
        check_eq("full_x2", {O_regwen, O_rd, O_data}, {1'b1, 4'd2, 32'h22});
        idle(3, 4, 2);

        // Reset in the middle of traffic
        run_cycle(1, 0, 0, '0, 1, 1, 0, '0, 1, 2);
        run_cycle(1, 0, 0, '0, 1, 2, 0, '0, 1, 2);
        run_cycle(1, 1, 6, 32'h66, 1, 8, 1, 32'h77, 1, 2);
        run_cycle(0, 1, 6, 32'h66, 0, 0, 1, 32'h88, 1, 2);
        idle(4, 1, 2);
        check_eq("midreset_quiet", {O_regwen, O_ld_ready}, 2'b00);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            run_cycle($urandom_range(0, 199) != 0,
                      $urandom_range(0, 9) < 4, $urandom_range(0, 15), $urandom,
                      $urandom_range(0, 1), $urandom_range(0, 15),
                      $urandom_range(0, 1), $urandom,
                      $urandom_range(0, 15), $urandom_range(0, 15));
        end
        idle(4, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
